// File: rtl/btn_pkg.sv
// Shared defaults, FSM encoding and width helper for the button event arbiter.
package btn_pkg;

  localparam int DEBOUNCE_COUNT_DEF = 5_000_000;
  localparam int LONG_COUNT_DEF     = 100_000_000;
  localparam int HOLD_W             = 27;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // Event index width; a single bit is kept even for the smallest configuration.
  function automatic int calc_idw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Valid/ready event channel from the button arbiter to the display mode controller.
interface button_event_arbiter_if #(
  parameter int IDW = 2
);

  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  logic           evt_long;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_long,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_long,
    output evt_ready
  );

endinterface

// File: rtl/debounce_button.sv
// Two-flop synchroniser followed by a stability counter; lvl follows the pin once it
// has disagreed with lvl for DEBOUNCE_COUNT+1 consecutive synchronised samples.
module debounce_button
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEF
) (
  input  logic clk,
  input  logic nrst,
  input  logic raw,
  output logic lvl
);

  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of the order the simulator runs processes in.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync <= '0;
      cnt  <= '0;
      lvl  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_COUNT)) begin
        lvl <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = btn_pkg::calc_idw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  // rot[j] is req[(ptr + j) mod N], so the lowest set bit is the winner's offset.
  assign rot = N'({req, req} >> ptr);

  // NOTE: every output gets a default before the search so no latch is inferred
  // on paths where nothing is requested.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    off     = '0;
    gnt_any = |rot;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = IW'(j);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    gnt_idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    for (int j = 0; j < N; j++) begin
      gnt[j] = gnt_any && (gnt_idx == IW'(j));
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounces N_BTN buttons, turns presses and long holds into pending events and hands
// them one at a time, round-robin, to the display controller over valid/ready.
module button_event_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEF,
  parameter int LONG_COUNT     = LONG_COUNT_DEF
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [N_BTN-1:0]       btn_raw,
  button_event_arbiter_if.master evt,
  output logic [N_BTN-1:0]       btn_level,
  output logic                   overflow
);

  localparam int IDW = calc_idw(N_BTN);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(LONG_COUNT);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_COUNT - 1);

  arb_state_t       state, state_nxt;
  logic [N_BTN-1:0] lvl, lvl_d;
  logic [N_BTN-1:0] pend_s, pend_l;
  logic [N_BTN-1:0] set_s, set_l, clr_s, clr_l;
  logic [N_BTN-1:0] req, gnt;
  logic [IDW-1:0]   gnt_idx, rr, id_q;
  logic             gnt_any, gnt_short, grant_en, offer, long_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [HOLD_W-1:0] hold;

    debounce_button #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
    ) u_db (
      .clk (clk),
      .nrst(nrst),
      .raw (btn_raw[i]),
      .lvl (lvl[i])
    );

    // Saturating hold timer; the long event fires on the single cycle it reaches the limit.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                hold <= '0;
      else if (!lvl[i])         hold <= '0;
      else if (hold != HOLD_LIM) hold <= hold + HOLD_W'(1);
    end

    assign set_l[i] = lvl[i] && (hold == HOLD_PRE);
  end

  assign set_s     = lvl & ~lvl_d;
  assign req       = pend_s | pend_l;
  assign btn_level = lvl;

  rr_arbiter #(
    .N (N_BTN),
    .IW(IDW)
  ) u_arb (
    .req    (req),
    .ptr    (rr),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_any(gnt_any)
  );

  // A granted channel hands out its short event first; the long one waits its next turn.
  assign gnt_short = |(gnt & pend_s);
  assign clr_s     = (grant_en && gnt_short)  ? gnt : '0;
  assign clr_l     = (grant_en && !gnt_short) ? gnt : '0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any)       state_nxt = OFFER;
      OFFER:   if (evt.evt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    offer    = (state == OFFER);
    grant_en = (state == IDLE) && gnt_any;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lvl_d    <= '0;
      pend_s   <= '0;
      pend_l   <= '0;
      overflow <= 1'b0;
      rr       <= '0;
      id_q     <= '0;
      long_q   <= 1'b0;
    end else begin
      lvl_d  <= lvl;
      // A set on a flag being granted this cycle wins and is not a drop.
      pend_s <= set_s | (pend_s & ~clr_s);
      pend_l <= set_l | (pend_l & ~clr_l);
      if (|((set_s & pend_s & ~clr_s) | (set_l & pend_l & ~clr_l))) overflow <= 1'b1;
      if (grant_en) begin
        id_q   <= gnt_idx;
        long_q <= ~gnt_short;
        rr     <= (gnt_idx == IDW'(N_BTN - 1)) ? '0 : gnt_idx + IDW'(1);
      end
    end
  end

  assign evt.evt_valid = offer;
  assign evt.evt_id    = id_q;
  assign evt.evt_long  = long_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed scenarios plus a randomized soak, all checked cycle by cycle against an
// event-level reference model of the button arbiter.
module tb_button_event_arbiter;
  import btn_pkg::*;

  localparam int N     = 4;
  localparam int DEB   = 4;
  localparam int LONGC = 20;
  localparam int IDW   = calc_idw(N);

  typedef struct {
    int id;
    bit lng;
    int cyc;
  } xfer_t;

  logic         clk     = 1'b0;
  logic         nrst    = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic         overflow;

  button_event_arbiter_if #(.IDW(IDW)) ev ();

  button_event_arbiter #(
    .N_BTN         (N),
    .DEBOUNCE_COUNT(DEB),
    .LONG_COUNT    (LONGC)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .btn_raw  (btn_raw),
    .evt      (ev),
    .btn_level(btn_level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  xfer_t xfers[$];
  int    lvl_c, val_c;
  int    exp_rr[4] = '{0, 1, 3, 0};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: a pin counts as settled when the D+1 synchronised samples all
  // disagree with the current level; events come from rise times and elapsed cycles.
  logic [N-1:0] m_hist[DEB+3];
  logic [N-1:0] m_lvl, m_ps, m_pl;
  int           m_rise[N];
  int           m_edge = 0;
  int           m_rr, m_id;
  bit           m_offer, m_long, m_ovf;

  task automatic m_reset();
    for (int x = 0; x < DEB + 3; x++) m_hist[x] = '0;
    for (int i = 0; i < N; i++) m_rise[i] = -1000000;
    m_lvl = '0; m_ps = '0; m_pl = '0;
    m_rr = 0; m_id = 0; m_offer = 0; m_long = 0; m_ovf = 0;
  endtask

  task automatic m_step();
    logic [N-1:0] nl, ss, sl, cs, cl;
    bit settled, found;
    int k, w;
    m_edge++;
    for (int x = DEB + 2; x > 0; x--) m_hist[x] = m_hist[x-1];
    m_hist[0] = btn_raw;
    nl = m_lvl;
    for (int i = 0; i < N; i++) begin
      settled = 1;
      for (int j = 0; j <= DEB; j++) if (m_hist[2+j][i] == m_lvl[i]) settled = 0;
      if (settled) nl[i] = ~m_lvl[i];
      ss[i] = m_lvl[i] && (m_edge == m_rise[i] + 1);
      sl[i] = m_lvl[i] && (m_edge == m_rise[i] + LONGC);
    end
    cs = '0; cl = '0; found = 0; w = 0;
    if (!m_offer && (m_ps | m_pl) != '0) begin
      for (int j = 0; j < N; j++) begin
        k = (m_rr + j) % N;
        if (!found && (m_ps[k] || m_pl[k])) begin found = 1; w = k; end
      end
      m_id = w;
      m_long = !m_ps[w];
      if (m_ps[w]) cs[w] = 1'b1; else cl[w] = 1'b1;
      m_rr = (w + 1) % N;
      m_offer = 1;
    end else if (m_offer && ev.evt_ready) begin
      m_offer = 0;
    end
    if (((ss & m_ps & ~cs) | (sl & m_pl & ~cl)) != '0) m_ovf = 1;
    m_ps = ss | (m_ps & ~cs);
    m_pl = sl | (m_pl & ~cl);
    for (int i = 0; i < N; i++) if (nl[i] && !m_lvl[i]) m_rise[i] = m_edge;
    m_lvl = nl;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) m_reset();
      else       m_step();
    end
  end

  // Per-cycle comparison on the falling edge, plus a log of completed transfers.
  initial begin
    @(posedge nrst);
    forever begin
      @(negedge clk);
      cyc++;
      check("evt_valid", ev.evt_valid, m_offer);
      if (m_offer) begin
        check("evt_id", ev.evt_id, m_id);
        check("evt_long", ev.evt_long, m_long);
      end
      check("btn_level", btn_level, m_lvl);
      check("overflow", overflow, m_ovf);
      if (ev.evt_valid && ev.evt_ready) xfers.push_back('{int'(ev.evt_id), ev.evt_long, cyc});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int c = 0;
    while (!ev.evt_valid && c < max_cyc) begin
      tick(1);
      c++;
    end
    check({tag, "_timeout"}, ev.evt_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ev.evt_ready = 1'b1;
    tick(4);
    nrst = 1'b1;
    tick(2);
    check("rst_valid", ev.evt_valid, 0);
    check("rst_id", ev.evt_id, 0);
    check("rst_long", ev.evt_long, 0);
    check("rst_level", btn_level, 0);
    check("rst_overflow", overflow, 0);

    // Single glitchy press on button 2.
    xfers.delete();
    lvl_c = -1;
    val_c = -1;
    for (int c = 0; c < 45; c++) begin
      btn_raw[2] = (c != 1) && (c < 13);
      tick(1);
      if (lvl_c < 0 && btn_level[2]) lvl_c = c;
      if (val_c < 0 && ev.evt_valid) val_c = c;
    end
    check("sp_latency", val_c - lvl_c, 2);
    check("sp_count", xfers.size(), 1);
    if (xfers.size() > 0) begin
      check("sp_id", xfers[0].id, 2);
      check("sp_long", xfers[0].lng, 0);
    end

    // Long hold on button 1: short event, then long event LONGC cycles after the rise.
    xfers.delete();
    btn_raw[1] = 1'b1;
    tick(40);
    btn_raw[1] = 1'b0;
    tick(40);
    check("lh_count", xfers.size(), 2);
    if (xfers.size() == 2) begin
      check("lh_id0", xfers[0].id, 1);
      check("lh_long0", xfers[0].lng, 0);
      check("lh_id1", xfers[1].id, 1);
      check("lh_long1", xfers[1].lng, 1);
      check("lh_gap", xfers[1].cyc - xfers[0].cyc, LONGC - 1);
    end

    // Round-robin from a fresh pointer, then wrap back to button 0.
    nrst = 1'b0;
    tick(2);
    nrst = 1'b1;
    tick(2);
    xfers.delete();
    btn_raw = 4'b1011;
    tick(10);
    btn_raw = '0;
    tick(30);
    btn_raw = 4'b0001;
    tick(10);
    btn_raw = '0;
    tick(30);
    check("rr_count", xfers.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < xfers.size()) begin
        check("rr_id", xfers[i].id, exp_rr[i]);
        check("rr_long", xfers[i].lng, 0);
      end
    end

    // Backpressure: offered event stays stable, a press during the stall follows.
    xfers.delete();
    ev.evt_ready = 1'b0;
    btn_raw[2] = 1'b1;
    wait_valid("bp", 40);
    btn_raw[2] = 1'b0;
    btn_raw[0] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      if (c == 10) btn_raw[0] = 1'b0;
      check("bp_valid", ev.evt_valid, 1);
      check("bp_id", ev.evt_id, 2);
      check("bp_long", ev.evt_long, 0);
    end
    ev.evt_ready = 1'b1;
    tick(30);
    check("bp_count", xfers.size(), 2);
    if (xfers.size() == 2) begin
      check("bp_first", xfers[0].id, 2);
      check("bp_second", xfers[1].id, 0);
      check("bp_second_long", xfers[1].lng, 0);
    end
    check("bp_no_overflow", overflow, 0);

    // Overflow: button 3 pressed twice while the channel is stalled on button 1.
    xfers.delete();
    ev.evt_ready = 1'b0;
    btn_raw[1] = 1'b1;
    tick(10);
    btn_raw[1] = 1'b0;
    wait_valid("ov", 40);
    repeat (2) begin
      btn_raw[3] = 1'b1;
      tick(10);
      btn_raw[3] = 1'b0;
      tick(10);
    end
    check("ov_flag", overflow, 1);
    ev.evt_ready = 1'b1;
    tick(30);
    check("ov_count", xfers.size(), 2);
    if (xfers.size() == 2) begin
      check("ov_first", xfers[0].id, 1);
      check("ov_second", xfers[1].id, 3);
    end
    check("ov_sticky", overflow, 1);

    // Reset while an event is offered.
    xfers.delete();
    ev.evt_ready = 1'b0;
    btn_raw[2] = 1'b1;
    wait_valid("rm", 40);
    btn_raw[2] = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    check("rm_valid", ev.evt_valid, 0);
    check("rm_id", ev.evt_id, 0);
    check("rm_long", ev.evt_long, 0);
    check("rm_level", btn_level, 0);
    check("rm_overflow", overflow, 0);
    tick(2);
    nrst = 1'b1;
    ev.evt_ready = 1'b1;
    tick(30);
    check("rm_stale", xfers.size(), 0);

    // Randomized soak with glitches, long holds and random backpressure.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 23) == 0) btn_raw[i] = ~btn_raw[i];
      end
      ev.evt_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    btn_raw = '0;
    ev.evt_ready = 1'b1;
    tick(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
